// File: rtl/vt52_pkg.sv
// Shared types and byte constants for the VT52 command engine.
package vt52_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ESC,
    ST_ESC_Y_ROW,
    ST_ESC_Y_COL
  } state_t;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  localparam logic [7:0] ESC_UP      = 8'h41; // A
  localparam logic [7:0] ESC_DOWN    = 8'h42; // B
  localparam logic [7:0] ESC_RIGHT   = 8'h43; // C
  localparam logic [7:0] ESC_LEFT    = 8'h44; // D
  localparam logic [7:0] ESC_HOME    = 8'h48; // H
  localparam logic [7:0] ESC_RLF     = 8'h49; // I
  localparam logic [7:0] ESC_CLR_EOS = 8'h4A; // J
  localparam logic [7:0] ESC_CLR_EOL = 8'h4B; // K
  localparam logic [7:0] ESC_ADDR    = 8'h59; // Y
  localparam logic [7:0] ESC_REV_ON  = 8'h70; // p
  localparam logic [7:0] ESC_REV_OFF = 8'h71; // q

endpackage

// File: rtl/vt52_cmd_engine_if.sv
// Byte stream in, char-buffer / cursor / scroll updates out.
interface vt52_cmd_engine_if #(
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
);
  logic [7:0]           data;
  logic                 valid;
  logic                 ready;
  logic [7:0]           new_char;
  logic [ADDR_BITS-1:0] new_char_address;
  logic                 new_char_wen;
  logic [COL_BITS-1:0]  new_cursor_x;
  logic [ROW_BITS-1:0]  new_cursor_y;
  logic                 new_cursor_wen;
  logic [ADDR_BITS-1:0] new_first_char;
  logic                 new_first_char_wen;
  logic                 busy;

  modport master (
    output data, valid,
    input  ready, new_char, new_char_address, new_char_wen, new_cursor_x, new_cursor_y,
           new_cursor_wen, new_first_char, new_first_char_wen, busy
  );
  modport slave (
    input  data, valid,
    output ready, new_char, new_char_address, new_char_wen, new_cursor_x, new_cursor_y,
           new_cursor_wen, new_first_char, new_first_char_wen, busy
  );
endinterface

// File: rtl/vt52_addr_calc.sv
// (first_char, x, y) -> buffer address, wrapping at ROWS*COLS.
module vt52_addr_calc #(
  parameter int ROWS      = 25,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input  logic [ADDR_BITS-1:0] first_char,
  input  logic [COL_BITS-1:0]  x,
  input  logic [ROW_BITS-1:0]  y,
  output logic [ADDR_BITS-1:0] addr
);
  localparam int W = ADDR_BITS + 1;
  logic [W-1:0] sum;

  // Both terms are below ROWS*COLS, so a single conditional subtract suffices.
  always_comb begin
    sum  = W'(first_char) + W'(y) * W'(COLS) + W'(x);
    addr = (sum >= W'(ROWS * COLS)) ? ADDR_BITS'(sum - W'(ROWS * COLS)) : sum[ADDR_BITS-1:0];
  end
endmodule

// File: rtl/vt52_cmd_engine.sv
// VT52 command engine: byte stream -> char writes, cursor, scroll, multi-cycle clears.
// Optional reverse-video flag (ESC p / ESC q) enabled by defining VT52_CMD_REVERSE_EN.
module vt52_cmd_engine
  import vt52_pkg::*;
#(
  parameter int ROWS      = 25,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11,
  parameter int TAB_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  vt52_cmd_engine_if.slave bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int CW    = ADDR_BITS + 1;

  state_t               state_q, state_d;
  logic [COL_BITS-1:0]  cx_q, cx_d;
  logic [ROW_BITS-1:0]  cy_q, cy_d;
  logic [ADDR_BITS-1:0] fc_q, fc_d, addr_q, addr_d, clr_addr_q, clr_addr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           char_q, char_d;
  logic                 char_wen_q, char_wen_d, cur_wen_q, cur_wen_d, fc_wen_q, fc_wen_d;
  logic [ADDR_BITS-1:0] cur_addr, fc_plus, fc_minus, clr_next;
  logic [COL_BITS:0]    tab_x;
  logic [7:0]           off;
  logic                 accept, do_lf, do_rlf, rev;

  vt52_addr_calc #(
    .ROWS(ROWS), .COLS(COLS), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .ADDR_BITS(ADDR_BITS)
  ) u_addr_calc (
    .first_char(fc_q), .x(cx_q), .y(cy_q), .addr(cur_addr)
  );

`ifdef VT52_CMD_REVERSE_EN
  logic rev_q, rev_d;
  assign rev = rev_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rev_q <= 1'b0;
    else       rev_q <= rev_d;
`else
  assign rev = 1'b0;
`endif

  assign bus.ready  = (state_q != ST_CLEAR);
  assign bus.busy   = (state_q == ST_CLEAR);
  assign accept     = bus.valid && bus.ready;

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    fc_d       = fc_q;
    cnt_d      = cnt_q;
    clr_addr_d = clr_addr_q;
    char_d     = char_q;
    addr_d     = addr_q;
    char_wen_d = 1'b0;
    fc_wen_d   = 1'b0;
    do_lf      = 1'b0;
    do_rlf     = 1'b0;
`ifdef VT52_CMD_REVERSE_EN
    rev_d      = rev_q;
`endif
    fc_plus  = (fc_q >= ADDR_BITS'(CELLS - COLS)) ? fc_q - ADDR_BITS'(CELLS - COLS)
                                                  : fc_q + ADDR_BITS'(COLS);
    fc_minus = (fc_q >= ADDR_BITS'(COLS)) ? fc_q - ADDR_BITS'(COLS)
                                          : fc_q + ADDR_BITS'(CELLS - COLS);
    clr_next = (clr_addr_q == ADDR_BITS'(CELLS - 1)) ? '0 : clr_addr_q + ADDR_BITS'(1);
    tab_x    = {1'b0, cx_q | COL_BITS'(TAB_W - 1)} + (COL_BITS + 1)'(1);
    off      = bus.data - CH_SPACE;

    case (state_q)
      // Extra cycle at cnt==0 keeps ready low until after the last write strobe.
      ST_CLEAR: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else begin
          char_wen_d = 1'b1;
          char_d     = CH_SPACE;
          addr_d     = clr_addr_q;
          clr_addr_d = clr_next;
          cnt_d      = cnt_q - CW'(1);
        end
      end
      ST_IDLE: if (accept) begin
        if (bus.data >= CH_SPACE && bus.data <= CH_TILDE) begin
          char_wen_d = 1'b1;
          char_d     = {rev, bus.data[6:0]};
          addr_d     = cur_addr;
          if (cx_q == COL_BITS'(COLS - 1)) begin
            cx_d  = '0;
            do_lf = 1'b1;
          end else cx_d = cx_q + COL_BITS'(1);
        end else begin
          case (bus.data)
            CH_CR:   cx_d = '0;
            CH_BS:   if (cx_q != '0) cx_d = cx_q - COL_BITS'(1);
            CH_TAB:  cx_d = (tab_x > (COL_BITS + 1)'(COLS - 1)) ? COL_BITS'(COLS - 1)
                                                                : tab_x[COL_BITS-1:0];
            CH_LF:   do_lf = 1'b1;
            CH_ESC:  state_d = ST_ESC;
            default: ;
          endcase
        end
      end
      ST_ESC: if (accept) begin
        state_d = ST_IDLE;
        case (bus.data)
          ESC_UP:    if (cy_q != '0) cy_d = cy_q - ROW_BITS'(1);
          ESC_DOWN:  if (cy_q != ROW_BITS'(ROWS - 1)) cy_d = cy_q + ROW_BITS'(1);
          ESC_RIGHT: if (cx_q != COL_BITS'(COLS - 1)) cx_d = cx_q + COL_BITS'(1);
          ESC_LEFT:  if (cx_q != '0) cx_d = cx_q - COL_BITS'(1);
          ESC_HOME:  begin cx_d = '0; cy_d = '0; end
          ESC_RLF:   do_rlf = 1'b1;
          ESC_CLR_EOS: begin
            clr_addr_d = cur_addr;
            cnt_d      = CW'(CELLS) - (CW'(cy_q) * CW'(COLS) + CW'(cx_q));
            state_d    = ST_CLEAR;
          end
          ESC_CLR_EOL: begin
            clr_addr_d = cur_addr;
            cnt_d      = CW'(COLS) - CW'(cx_q);
            state_d    = ST_CLEAR;
          end
          ESC_ADDR:  state_d = ST_ESC_Y_ROW;
`ifdef VT52_CMD_REVERSE_EN
          ESC_REV_ON:  rev_d = 1'b1;
          ESC_REV_OFF: rev_d = 1'b0;
`endif
          default: ;
        endcase
      end
      ST_ESC_Y_ROW: if (accept) begin
        state_d = ST_ESC_Y_COL;
        cy_d = (bus.data < CH_SPACE) ? '0 :
               (off > 8'(ROWS - 1)) ? ROW_BITS'(ROWS - 1) : ROW_BITS'(off);
      end
      ST_ESC_Y_COL: if (accept) begin
        state_d = ST_IDLE;
        cx_d = (bus.data < CH_SPACE) ? '0 :
               (off > 8'(COLS - 1)) ? COL_BITS'(COLS - 1) : COL_BITS'(off);
      end
      default: state_d = ST_CLEAR;
    endcase

    // Scrolling moves the window, then blanks the line that just became visible.
    if (do_lf) begin
      if (cy_q != ROW_BITS'(ROWS - 1)) cy_d = cy_q + ROW_BITS'(1);
      else begin
        fc_d       = fc_plus;
        fc_wen_d   = 1'b1;
        clr_addr_d = fc_q;
        cnt_d      = CW'(COLS);
        state_d    = ST_CLEAR;
      end
    end
    if (do_rlf) begin
      if (cy_q != '0) cy_d = cy_q - ROW_BITS'(1);
      else begin
        fc_d       = fc_minus;
        fc_wen_d   = 1'b1;
        clr_addr_d = fc_minus;
        cnt_d      = CW'(COLS);
        state_d    = ST_CLEAR;
      end
    end
    cur_wen_d = (cx_d != cx_q) || (cy_d != cy_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_CLEAR;
      cx_q       <= '0;
      cy_q       <= '0;
      fc_q       <= '0;
      cnt_q      <= CW'(CELLS);
      clr_addr_q <= '0;
      char_q     <= CH_SPACE;
      addr_q     <= '0;
      char_wen_q <= 1'b0;
      cur_wen_q  <= 1'b0;
      fc_wen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      fc_q       <= fc_d;
      cnt_q      <= cnt_d;
      clr_addr_q <= clr_addr_d;
      char_q     <= char_d;
      addr_q     <= addr_d;
      char_wen_q <= char_wen_d;
      cur_wen_q  <= cur_wen_d;
      fc_wen_q   <= fc_wen_d;
    end
  end

  assign bus.new_char           = char_q;
  assign bus.new_char_address   = addr_q;
  assign bus.new_char_wen       = char_wen_q;
  assign bus.new_cursor_x       = cx_q;
  assign bus.new_cursor_y       = cy_q;
  assign bus.new_cursor_wen     = cur_wen_q;
  assign bus.new_first_char     = fc_q;
  assign bus.new_first_char_wen = fc_wen_q;
endmodule

// File: tb/tb_vt52_cmd_engine.sv
// Directed bench for vt52_cmd_engine at the default 80x25 geometry.
module tb_vt52_cmd_engine;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [10:0] wq_addr[$];
  logic [7:0]  wq_char[$];

  vt52_cmd_engine_if bus ();
  vt52_cmd_engine dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rstn && bus.new_char_wen) begin
      wq_addr.push_back(bus.new_char_address);
      wq_char.push_back(bus.new_char);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.data  = b;
    bus.valid = 1'b1;
    while (!bus.ready && n < LIMIT) begin @(negedge clk); n++; end
    chk("send_timeout", {31'd0, bus.ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < LIMIT) begin @(negedge clk); n++; end
    chk("ready_timeout", {31'd0, bus.ready}, 32'd1);
  endtask

  task automatic clr_q();
    wq_addr.delete();
    wq_char.delete();
  endtask

  task automatic chk_clear(input string tag, input int n, input int base);
    int bad = 0;
    chk({tag, "_len"}, wq_addr.size(), n);
    foreach (wq_addr[i])
      if (wq_addr[i] != 11'((base + i) % 2000) || wq_char[i] != 8'h20) bad++;
    chk({tag, "_data"}, bad, 0);
  endtask

  task automatic chk_cur(input string tag, input int x, input int y, input bit wen);
    chk({tag, "_x"}, bus.new_cursor_x, x);
    chk({tag, "_y"}, bus.new_cursor_y, y);
    chk({tag, "_cwen"}, bus.new_cursor_wen, wen);
  endtask

  initial begin
    int k, bad;
    logic [7:0] rev_exp;
    bus.data  = 8'h00;
    bus.valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_char_wen", bus.new_char_wen, 0);
    chk("rst_cur_wen", bus.new_cursor_wen, 0);
    chk("rst_fc_wen", bus.new_first_char_wen, 0);
    chk("rst_char", bus.new_char, 8'h20);
    chk("rst_addr", bus.new_char_address, 0);
    chk("rst_x", bus.new_cursor_x, 0);
    chk("rst_y", bus.new_cursor_y, 0);
    chk("rst_fc", bus.new_first_char, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_busy", bus.busy, 1);

    // Power-on clear: 2000 blanks at 0..1999 with ready low throughout.
    rstn = 1'b1;
    k = 0; bad = 0;
    for (int c = 0; c < 2100 && !bus.ready; c++) begin
      @(negedge clk);
      if (bus.new_char_wen) begin
        if (bus.new_char_address != 11'(k) || bus.new_char != 8'h20 || bus.ready) bad++;
        k++;
      end
    end
    chk("init_clear_count", k, 2000);
    chk("init_clear_data", bad, 0);
    chk("init_ready", bus.ready, 1);
    chk("init_busy", bus.busy, 0);
    clr_q();

    send(8'h41);
    chk("A_wen", bus.new_char_wen, 1);
    chk("A_char", bus.new_char, 8'h41);
    chk("A_addr", bus.new_char_address, 0);
    chk_cur("A", 1, 0, 1);
    @(negedge clk);
    chk("A_wen_pulse", bus.new_char_wen, 0);
    chk("A_cwen_pulse", bus.new_cursor_wen, 0);
    send(8'h42);
    chk("B_char", bus.new_char, 8'h42);
    chk("B_addr", bus.new_char_address, 1);
    chk_cur("B", 2, 0, 1);

    send(8'h1B);
    chk("escY_nowen", bus.new_cursor_wen, 0);
    send(8'h59);
    send(8'h38);
    chk_cur("escY_row", 2, 24, 1);
    send(8'h20);
    chk_cur("escY_col", 0, 24, 1);

    // Scroll at bottom row.
    clr_q();
    send(8'h0A);
    chk("lf_fc_wen", bus.new_first_char_wen, 1);
    chk("lf_fc", bus.new_first_char, 80);
    chk("lf_busy", bus.busy, 1);
    chk("lf_ready", bus.ready, 0);
    chk("lf_char_wen", bus.new_char_wen, 0);
    chk("lf_cwen", bus.new_cursor_wen, 0);
    wait_ready();
    chk_clear("lf_clear", 80, 0);
    chk_cur("lf_cur", 0, 24, 0);

    for (int i = 0; i < 23; i++) begin send(8'h0A); wait_ready(); end
    chk("fc_1920", bus.new_first_char, 1920);
    send(8'h0A);
    chk("fc_wrap_wen", bus.new_first_char_wen, 1);
    chk("fc_wrap", bus.new_first_char, 0);
    wait_ready();

    send(8'h1B); send(8'h48);
    chk_cur("home", 0, 0, 1);
    clr_q();
    send(8'h1B); send(8'h49);
    chk("rlf_fc_wen", bus.new_first_char_wen, 1);
    chk("rlf_fc", bus.new_first_char, 1920);
    wait_ready();
    chk_clear("rlf_clear", 80, 1920);
    chk_cur("rlf_cur", 0, 0, 0);

    send(8'h1B); send(8'h59); send(8'h3F); send(8'h7F);
    chk("clamp_x", bus.new_cursor_x, 79);
    chk("clamp_y", bus.new_cursor_y, 24);

    clr_q();
    send(8'h0A);
    chk("lf2_fc", bus.new_first_char, 0);
    wait_ready();
    chk_clear("lf2_clear", 80, 1920);

    send(8'h1B); send(8'h59); send(8'h23); send(8'h6E);
    chk_cur("pos_78_3", 78, 3, 1);
    clr_q();
    send(8'h1B); send(8'h4B);
    chk("eol_busy", bus.busy, 1);
    wait_ready();
    chk_clear("eol_clear", 2, 318);
    chk_cur("eol_cur", 78, 3, 0);

    send(8'h78);
    chk("x_addr", bus.new_char_address, 318);
    send(8'h79);
    chk("wrap_addr", bus.new_char_address, 319);
    chk("wrap_char", bus.new_char, 8'h79);
    chk_cur("wrap", 0, 4, 1);

    send(8'h09); chk_cur("tab", 8, 4, 1);
    send(8'h08); chk_cur("bs", 7, 4, 1);
    send(8'h0D); chk_cur("cr", 0, 4, 1);
    send(8'h08); chk_cur("bs_sat", 0, 4, 0);
    send(8'h80);
    chk("hi_ignored", bus.new_char_wen, 0);
    send(8'h1B); send(8'h41); chk_cur("esc_up", 0, 3, 1);
    send(8'h1B); send(8'h44); chk_cur("esc_left_sat", 0, 3, 0);
    send(8'h1B); send(8'h59); send(8'h23); send(8'h6C);
    send(8'h09); chk_cur("tab_sat", 79, 3, 1);
    send(8'h1B); send(8'h43); chk_cur("esc_right_sat", 79, 3, 0);

`ifdef VT52_CMD_REVERSE_EN
    rev_exp = 8'hC1;
`else
    rev_exp = 8'h41;
`endif
    send(8'h1B); send(8'h70);
    send(8'h41);
    chk("rev_on_char", bus.new_char, rev_exp);
    chk("rev_on_addr", bus.new_char_address, 319);
    send(8'h1B); send(8'h71);
    send(8'h41);
    chk("rev_off_char", bus.new_char, 8'h41);
    chk("rev_off_addr", bus.new_char_address, 320);

    // Full clear from home while the next byte waits with valid held high.
    send(8'h1B); send(8'h48);
    clr_q();
    send(8'h1B); send(8'h4A);
    send(8'h51);
    chk("held_char", bus.new_char, 8'h51);
    chk("held_addr", bus.new_char_address, 0);
    @(negedge clk);
    chk("eos_len", wq_addr.size(), 2001);
    chk("eos_first", wq_addr[0], 0);
    chk("eos_last", wq_addr[1999], 1999);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
